// File: rtl/super_sys_seq.sv
`default_nettype none
// ============================================================================
// Module      : super_sys_seq
// Description : Command sequencer for a grid of systolic tiles. Accepts a
//               command, optionally shifts in weights, streams activation
//               vectors with a skewed per-row enable, then drains the array
//               and pulses done. Fused mode treats the grid as one tall
//               array; split mode runs each tile row independently.
//               Optional macro SUPER_SYS_PERF_CNT_EN adds the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module super_sys_seq #(
    parameter int GRID_ROWS = 2,
    parameter int GRID_COLS = 2,
    parameter int TILE_ROWS = 4,
    parameter int TILE_COLS = 4,
    parameter int LEN_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_mode,
    input  logic                           cmd_wload,
    input  logic [LEN_W-1:0]               cmd_len,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic                           a_valid,
    output logic                           a_ready,
    output logic [GRID_COLS*TILE_COLS-1:0] wfetch,
    output logic [GRID_ROWS-2:0]           w_mux_sel,
    output logic                           if_mux_sel,
    output logic [GRID_ROWS*TILE_ROWS-1:0] if_en,
    output logic                           of_valid,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    stall_cnt
);

    localparam int c_AC    = GRID_COLS * TILE_COLS;
    localparam int c_NR    = GRID_ROWS * TILE_ROWS;
    localparam int c_LAT_F = c_NR + c_AC - 1;
    localparam int c_LAT_S = TILE_ROWS + c_AC - 1;
    // Delay line is sized for the longer (fused) latency; split mode taps earlier.
    localparam int c_DLY_W = c_LAT_F + 1;
    localparam int c_BCW   = $clog2(c_NR + 1);
    localparam logic [c_BCW-1:0] c_LAST_F = c_BCW'(c_NR - 1);
    localparam logic [c_BCW-1:0] c_LAST_S = c_BCW'(TILE_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WLOAD  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_cmd_ready;
    logic                  r_mode;
    logic [LEN_W-1:0]      r_len;
    logic [c_BCW-1:0]      r_beats;
    logic [c_DLY_W-1:0]    r_dly;
    logic [GRID_ROWS-2:0]  r_w_mux_sel;
    logic                  r_if_mux_sel;
    logic                  w_accept;
    logic                  w_beat;
    logic                  w_e0;
    logic                  w_last_beat;
    logic                  w_last_vec;

    // r_cmd_ready is only ever high in IDLE, so it alone qualifies acceptance.
    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_beat      = (r_state == S_WLOAD) & w_valid;
    assign w_e0        = (r_state == S_STREAM) & a_valid;
    assign w_last_beat = w_beat & (r_beats == (r_mode ? c_LAST_S : c_LAST_F));
    assign w_last_vec  = w_e0 & (r_len == LEN_W'(1));

    // Next-state decode and state-derived handshake/status outputs.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        a_ready = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    if (cmd_wload)
                        w_next = S_WLOAD;
                    else if (cmd_len != '0)
                        w_next = S_STREAM;
                    else
                        w_next = S_DRAIN;
                end
            end
            S_WLOAD: begin
                w_ready = 1'b1;
                if (w_last_beat)
                    w_next = (r_len != '0) ? S_STREAM : S_DRAIN;
            end
            S_STREAM: begin
                a_ready = 1'b1;
                if (w_last_vec)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_dly == '0)
                    w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, command latches, beat/vector counters and mux selects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_mode       <= 1'b0;
            r_len        <= '0;
            r_beats      <= '0;
            r_w_mux_sel  <= '0;
            r_if_mux_sel <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_mode       <= cmd_mode;
                r_len        <= cmd_len;
                r_beats      <= '0;
                r_w_mux_sel  <= {(GRID_ROWS-1){cmd_mode}};
                r_if_mux_sel <= cmd_mode;
            end else begin
                if (w_beat)
                    r_beats <= r_beats + 1'b1;
                if (w_e0)
                    r_len <= r_len - 1'b1;
            end
        end
    end

    // Enable delay line: bit k carries e0 delayed by k+1 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_dly <= '0;
        else
            r_dly <= {r_dly[c_DLY_W-2:0], w_e0};
    end

    // Split mode restarts the skew at the top of every tile row.
    for (genvar gr = 0; gr < c_NR; gr++) begin : g_if_en
        assign if_en[gr] = r_mode ? r_dly[gr % TILE_ROWS] : r_dly[gr];
    end

    assign of_valid   = r_mode ? r_dly[c_LAT_S] : r_dly[c_LAT_F];
    assign wfetch     = {c_AC{w_beat}};
    assign cmd_ready  = r_cmd_ready;
    assign w_mux_sel  = r_w_mux_sel;
    assign if_mux_sel = r_if_mux_sel;

`ifdef SUPER_SYS_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of STREAM cycles without an activation vector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_accept)
            r_stall_cnt <= '0;
        else if ((r_state == S_STREAM) && !a_valid && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_super_sys_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_super_sys_seq
// Description : Self-checking bench for super_sys_seq with default grid
//               parameters (AC=8, fused AR=8/LAT=15, split AR=4/LAT=11).
//               Expected of_valid cycles are queued when vectors are driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_super_sys_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_mode = 1'b0;
    logic        cmd_wload = 1'b0;
    logic [15:0] cmd_len = '0;
    logic        w_valid = 1'b0;
    logic        a_valid = 1'b0;
    logic        cmd_ready, w_ready, a_ready, if_mux_sel, of_valid, busy, done;
    logic [7:0]  wfetch;
    logic [0:0]  w_mux_sel;
    logic [7:0]  if_en;
    logic [31:0] stall_cnt;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    // Expected per-cycle behaviour, set by the driving tasks from the command timeline.
    bit          mon_on = 1'b0;
    bit          exp_e0 = 1'b0, exp_wl = 1'b0, exp_st = 1'b0, exp_busy = 1'b0;
    bit          exp_cready = 1'b0, exp_sel = 1'b0, exp_mode = 1'b0;
    logic [63:0] hist = '0;
    int          of_q[$];
    int          mon_beats = 0, mon_wf = 0, mon_of = 0, mon_done = 0;

`ifdef SUPER_SYS_PERF_CNT_EN
    localparam int c_EXP_STALL = 2;
`else
    localparam int c_EXP_STALL = 0;
`endif

    super_sys_seq #(
        .GRID_ROWS (2),
        .GRID_COLS (2),
        .TILE_ROWS (4),
        .TILE_COLS (4),
        .LEN_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_wload  (cmd_wload),
        .cmd_len    (cmd_len),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .wfetch     (wfetch),
        .w_mux_sel  (w_mux_sel),
        .if_mux_sel (if_mux_sel),
        .if_en      (if_en),
        .of_valid   (of_valid),
        .busy       (busy),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Sample outputs on the falling edge against the expected timeline, then
    // advance to just after the next rising edge.
    task automatic step();
        logic [13:0] act, expv;
        logic [7:0]  exp_if;
        bit          exp_of;
        @(negedge clk);
        if (mon_on) begin
            hist = rst ? {hist[62:0], exp_e0} : '0;
            for (int r = 0; r < 8; r++)
                exp_if[r] = hist[exp_mode ? (r % 4) + 1 : r + 1];
            n_chk++;
            if (if_en !== exp_if)
                $display("FAIL if_en cyc=%0d: got %b want %b", cyc, if_en, exp_if);
            else
                n_pass++;
            act  = {cmd_ready, busy, w_ready, a_ready, w_mux_sel, if_mux_sel, wfetch};
            expv = {exp_cready, exp_busy, exp_wl, exp_st, exp_sel, exp_sel, {8{w_valid & exp_wl}}};
            n_chk++;
            if (act !== expv)
                $display("FAIL ctrl cyc=%0d: got %b want %b (rdy,busy,wr,ar,wsel,isel,wfetch)", cyc, act, expv);
            else
                n_pass++;
            while (of_q.size() > 0 && of_q[0] < cyc)
                void'(of_q.pop_front());
            exp_of = (of_q.size() > 0) && (of_q[0] == cyc);
            if (exp_of)
                void'(of_q.pop_front());
            n_chk++;
            if (of_valid !== exp_of)
                $display("FAIL of_valid cyc=%0d: got %b want %b", cyc, of_valid, exp_of);
            else
                n_pass++;
            if (w_valid && w_ready) mon_beats++;
            if (wfetch != '0)       mon_wf++;
            if (of_valid)           mon_of++;
            if (done)               mon_done++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive one command from IDLE through DONE; ends in the cycle after DONE.
    task automatic run_cmd(input bit mode, input bit wl, input int len, input bit wtog,
                           input int gap_at, input int gap_len, input bit hold,
                           output int drain_cyc, output bit timeout);
        int lat, ar, beats, sent, gap, k;
        lat = mode ? 11 : 15;
        ar  = mode ? 4 : 8;
        beats = 0; sent = 0; gap = 0; k = 0;
        cmd_valid = 1'b1; cmd_mode = mode; cmd_wload = wl; cmd_len = 16'(len);
        w_valid = 1'b1; a_valid = 1'b1;
        exp_wl = 1'b0; exp_st = 1'b0; exp_e0 = 1'b0; exp_busy = 1'b0; exp_cready = 1'b1;
        step();
        // Conflicting fields while busy must be ignored.
        cmd_valid = hold; cmd_mode = ~mode; cmd_wload = ~wl; cmd_len = 16'(len + 5);
        exp_mode = mode; exp_sel = mode; exp_busy = 1'b1; exp_cready = 1'b0;
        if (wl) begin
            while (beats < ar) begin
                w_valid = wtog ? (k % 2 == 0) : 1'b1;
                k++;
                exp_wl = 1'b1;
                if (w_valid) beats++;
                step();
            end
            exp_wl = 1'b0;
        end
        w_valid = 1'b1;
        while (sent < len) begin
            exp_st  = 1'b1;
            a_valid = !(sent == gap_at && gap < gap_len);
            exp_e0  = a_valid;
            if (a_valid) begin
                of_q.push_back(cyc + lat + 1);
                sent++;
            end else begin
                gap++;
            end
            step();
        end
        exp_st = 1'b0; exp_e0 = 1'b0; a_valid = 1'b1;
        drain_cyc = 0;
        while (done !== 1'b1 && drain_cyc < 200) begin
            drain_cyc++;
            step();
        end
        timeout = (done !== 1'b1);
        step();
        cmd_valid = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        exp_busy = 1'b0; exp_cready = 1'b1;
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1; w_valid = 1'b1; a_valid = 1'b1;
        repeat (3) step();
        mon_on = 1'b1;
        n_chk++;
        if ({cmd_ready, busy, done, w_ready, a_ready, w_mux_sel, if_mux_sel} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0", {cmd_ready, busy, done, w_ready, a_ready, w_mux_sel, if_mux_sel});
        else
            n_pass++;
        n_chk++;
        if ({of_valid, if_en, wfetch, stall_cnt} !== 49'b0)
            $display("FAIL reset_data: got if_en=%b wfetch=%b of=%b stall=%0d want 0", if_en, wfetch, of_valid, stall_cnt);
        else
            n_pass++;
        step();
        cmd_valid = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_chk++;
        if (cmd_ready !== 1'b0) $display("FAIL release_ready0: got %b want 0", cmd_ready);
        else n_pass++;
        step();
        exp_cready = 1'b1;
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL release_ready1: got %b want 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_fused_wload();
        int d, b0, w0, o0, n0;
        bit to;
        b0 = mon_beats; w0 = mon_wf; o0 = mon_of; n0 = mon_done;
        run_cmd(1'b0, 1'b1, 3, 1'b0, -1, 0, 1'b0, d, to);
        n_chk++; if (to) $display("FAIL fused_timeout: got no done want done"); else n_pass++;
        n_chk++; if (mon_beats - b0 != 8) $display("FAIL fused_beats: got %0d want 8", mon_beats - b0); else n_pass++;
        n_chk++; if (mon_wf - w0 != 8) $display("FAIL fused_wfetch: got %0d want 8", mon_wf - w0); else n_pass++;
        n_chk++; if (mon_of - o0 != 3) $display("FAIL fused_of: got %0d want 3", mon_of - o0); else n_pass++;
        n_chk++; if (mon_done - n0 != 1) $display("FAIL fused_done: got %0d want 1", mon_done - n0); else n_pass++;
    endtask

    task automatic test_split();
        int d, b0, w0, o0, n0;
        bit to;
        b0 = mon_beats; w0 = mon_wf; o0 = mon_of; n0 = mon_done;
        run_cmd(1'b1, 1'b1, 2, 1'b0, -1, 0, 1'b0, d, to);
        n_chk++; if (to) $display("FAIL split_timeout: got no done want done"); else n_pass++;
        n_chk++; if (mon_beats - b0 != 4) $display("FAIL split_beats: got %0d want 4", mon_beats - b0); else n_pass++;
        n_chk++; if (mon_wf - w0 != 4) $display("FAIL split_wfetch: got %0d want 4", mon_wf - w0); else n_pass++;
        n_chk++; if (mon_of - o0 != 2) $display("FAIL split_of: got %0d want 2", mon_of - o0); else n_pass++;
        n_chk++; if (mon_done - n0 != 1) $display("FAIL split_done: got %0d want 1", mon_done - n0); else n_pass++;
        n_chk++;
        if ({w_mux_sel, if_mux_sel} !== 2'b11) $display("FAIL split_sel_hold: got %b want 11", {w_mux_sel, if_mux_sel});
        else n_pass++;
    endtask

    task automatic test_stall();
        int d, w0, o0;
        bit to;
        w0 = mon_wf; o0 = mon_of;
        run_cmd(1'b0, 1'b0, 4, 1'b0, 2, 2, 1'b0, d, to);
        n_chk++; if (to) $display("FAIL stall_timeout: got no done want done"); else n_pass++;
        n_chk++; if (mon_wf - w0 != 0) $display("FAIL stall_wfetch: got %0d want 0", mon_wf - w0); else n_pass++;
        n_chk++; if (mon_of - o0 != 4) $display("FAIL stall_of: got %0d want 4", mon_of - o0); else n_pass++;
        n_chk++;
        if (stall_cnt !== 32'(c_EXP_STALL)) $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, c_EXP_STALL);
        else n_pass++;
    endtask

    task automatic test_len0();
        int d, w0, o0, n0;
        bit to;
        w0 = mon_wf; o0 = mon_of; n0 = mon_done;
        run_cmd(1'b0, 1'b0, 0, 1'b0, -1, 0, 1'b0, d, to);
        n_chk++; if (to) $display("FAIL len0_timeout: got no done want done"); else n_pass++;
        n_chk++; if (d != 1) $display("FAIL len0_drain: got %0d drain cycles want 1", d); else n_pass++;
        n_chk++; if (mon_wf - w0 != 0) $display("FAIL len0_wfetch: got %0d want 0", mon_wf - w0); else n_pass++;
        n_chk++; if (mon_of - o0 != 0) $display("FAIL len0_of: got %0d want 0", mon_of - o0); else n_pass++;
        n_chk++; if (mon_done - n0 != 1) $display("FAIL len0_done: got %0d want 1", mon_done - n0); else n_pass++;
        n_chk++; if (stall_cnt !== 32'd0) $display("FAIL len0_stall_clear: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_wtoggle();
        int d, b0, w0, o0;
        bit to;
        b0 = mon_beats; w0 = mon_wf; o0 = mon_of;
        run_cmd(1'b0, 1'b1, 1, 1'b1, -1, 0, 1'b0, d, to);
        n_chk++; if (to) $display("FAIL wtog_timeout: got no done want done"); else n_pass++;
        n_chk++; if (mon_beats - b0 != 8) $display("FAIL wtog_beats: got %0d want 8", mon_beats - b0); else n_pass++;
        n_chk++; if (mon_wf - w0 != 8) $display("FAIL wtog_wfetch: got %0d want 8", mon_wf - w0); else n_pass++;
        n_chk++; if (mon_of - o0 != 1) $display("FAIL wtog_of: got %0d want 1", mon_of - o0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d, o0, n0;
        bit to1, to2;
        o0 = mon_of; n0 = mon_done;
        run_cmd(1'b1, 1'b0, 3, 1'b0, -1, 0, 1'b1, d, to1);
        run_cmd(1'b0, 1'b1, 2, 1'b0, -1, 0, 1'b0, d, to2);
        n_chk++; if (to1 || to2) $display("FAIL b2b_timeout: got %b%b want 00", to1, to2); else n_pass++;
        n_chk++; if (mon_of - o0 != 5) $display("FAIL b2b_of: got %0d want 5", mon_of - o0); else n_pass++;
        n_chk++; if (mon_done - n0 != 2) $display("FAIL b2b_done: got %0d want 2", mon_done - n0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int o0, n0;
        cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_wload = 1'b0; cmd_len = 16'd8;
        a_valid = 1'b1; exp_cready = 1'b1; exp_busy = 1'b0;
        step();
        cmd_valid = 1'b0;
        exp_mode = 1'b0; exp_sel = 1'b0; exp_busy = 1'b1; exp_cready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_st = 1'b1; exp_e0 = 1'b1;
            of_q.push_back(cyc + 16);
            step();
        end
        rst = 1'b0;
        of_q.delete();
        exp_st = 1'b0; exp_e0 = 1'b0; exp_busy = 1'b0;
        #1;
        n_chk++;
        if ({of_valid, if_en, busy, done, cmd_ready, a_ready} !== 13'b0)
            $display("FAIL abort_outputs: got of=%b if_en=%b busy=%b done=%b rdy=%b ar=%b want 0",
                     of_valid, if_en, busy, done, cmd_ready, a_ready);
        else
            n_pass++;
        step();
        step();
        a_valid = 1'b0;
        rst = 1'b1;
        o0 = mon_of; n0 = mon_done;
        #1;
        n_chk++; if (cmd_ready !== 1'b0) $display("FAIL abort_ready0: got %b want 0", cmd_ready); else n_pass++;
        step();
        exp_cready = 1'b1;
        n_chk++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready1: got %b want 1", cmd_ready); else n_pass++;
        repeat (30) step();
        n_chk++; if (mon_of != o0) $display("FAIL abort_of: got %0d want 0", mon_of - o0); else n_pass++;
        n_chk++; if (mon_done != n0) $display("FAIL abort_done: got %0d want 0", mon_done - n0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fused_wload();
        test_split();
        test_stall();
        test_len0();
        test_wtoggle();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/super_sys_seq.md
SUPER_SYS_SEQ -- requirements
Module: super_sys_seq

Interface
REQ-001 Parameter GRID_ROWS, default 2, tile rows in the grid; the value SHALL be at least 2.
REQ-002 Parameter GRID_COLS, default 2, tile columns in the grid.
REQ-003 Parameter TILE_ROWS, default 4, PE rows per tile.
REQ-004 Parameter TILE_COLS, default 4, PE columns per tile.
REQ-005 Parameter LEN_W, default 16, width of the stream-length field.
REQ-006 Derived values: AC = GRID_COLS*TILE_COLS; AR = GRID_ROWS*TILE_ROWS in fused mode, TILE_ROWS in split mode; LAT = AR+AC-1.
REQ-007 Ports, one per line as name / direction / width / meaning:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_mode  in  1  0 = fused (one tall array), 1 = split (independent tile rows)
- cmd_wload  in  1  1 = load weights before streaming
- cmd_len  in  LEN_W  number of activation vectors
- w_valid  in  1  weight beat available
- w_ready  out  1  module accepts weight beats
- a_valid  in  1  activation vector available
- a_ready  out  1  module accepts activation vectors
- wfetch  out  AC  weight-shift strobe per column
- w_mux_sel  out  GRID_ROWS-1  per tile-row boundary: 1 = external weights/bias, 0 = chained from tile above
- if_mux_sel  out  1  activation source select for lower tile rows
- if_en  out  GRID_ROWS*TILE_ROWS  skewed per-row activation enable
- of_valid  out  1  result row valid
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse
- stall_cnt  out  32  count of STREAM cycles with no activation

Function
REQ-008 The FSM SHALL have the states IDLE, WLOAD, STREAM, DRAIN and DONE; cmd_ready SHALL be a register that is 1 only in IDLE.
REQ-009 On acceptance, the FSM SHALL latch mode, wload and len, then go to WLOAD if wload=1, else STREAM if len>0, else DRAIN.
REQ-010 On acceptance, w_mux_sel SHALL become all-ones (split) or all-zeros (fused) and if_mux_sel SHALL equal mode; both SHALL hold until the next acceptance.
REQ-011 In WLOAD, w_ready SHALL be 1 and every wfetch bit SHALL equal w_valid in the same cycle; after AR accepted beats the FSM SHALL go to STREAM if len>0, else DRAIN.
REQ-012 In STREAM, a_ready SHALL be 1 and the row-0 enable e0 SHALL equal a_valid; each accepted vector SHALL decrement a counter, and the FSM SHALL enter DRAIN in the cycle after the len-th vector is accepted.
REQ-013 The enable outputs SHALL be registered: if_en[r] SHALL equal e0 delayed by (r+1) cycles in fused mode and by ((r mod TILE_ROWS)+1) cycles in split mode.
REQ-014 of_valid SHALL equal e0 delayed by LAT+1 cycles, with LAT taken from the latched mode.
REQ-015 DRAIN SHALL last until the enable delay line is empty; the FSM SHALL then enter DONE, where done=1 for exactly one cycle, and return to IDLE.
REQ-016 A new command SHALL NOT be accepted before the FSM is back in IDLE; cmd_valid outside IDLE SHALL be ignored.
REQ-017 When cmd_valid is high in IDLE, a command presented in the cycle that follows DONE SHALL be accepted.

Reset
REQ-018 While rst=0, every output, counter, delay line and the mux selects SHALL be 0 and the state SHALL be IDLE; cmd_ready SHALL become 1 on the first clock edge after reset is released.
REQ-019 A reset asserted mid-operation SHALL abort the operation: no of_valid and no done pulse SHALL follow.

Configuration
REQ-020 With SUPER_SYS_PERF_CNT_EN defined, stall_cnt SHALL increment in each STREAM cycle with a_valid=0, SHALL saturate at 2^32-1, and SHALL clear on command acceptance.
REQ-021 Without SUPER_SYS_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification (default parameters: AC=8; fused AR=8, LAT=15; split AR=4, LAT=11)
REQ-022 Fused, wload=1, len=3, w_valid and a_valid held high -> 8 wfetch cycles, w_mux_sel=0, of_valid high for 3 cycles starting 16 cycles after the first e0, then one done pulse.
REQ-023 Split, wload=1, len=2 -> 4 wfetch cycles, w_mux_sel=1, if_mux_sel=1, if_en[4] aligned with if_en[0], of_valid starting 12 cycles after the first e0.
REQ-024 Fused, wload=0, len=4, a_valid low for 2 cycles mid-stream -> 2-cycle bubble visible in every if_en bit and in of_valid, 4 of_valid cycles total, stall_cnt=2 (macro defined) or 0 (macro undefined).
REQ-025 wload=0, len=0 -> FSM passes IDLE -> DRAIN -> DONE, with no wfetch, no if_en and no of_valid, and a done pulse.
REQ-026 Reset pulled low 5 cycles into STREAM -> all outputs 0 at once, no subsequent of_valid or done, and cmd_ready=1 one cycle after release.
REQ-027 w_valid toggling during WLOAD in fused mode -> wfetch mirrors w_valid, and exactly 8 accepted beats are counted before STREAM.
